// File: rtl/pc_sequencer.sv
// Program-counter sequencer feeding a return-address stack: decodes control-flow ops,
// owns the PC, strobes the stack and inserts one settle cycle after every stack access.
module pc_sequencer #(
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] target,
  input  logic              zero,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] stk_push,
  output logic              stk_c,
  output logic              stk_en,
  input  logic [ADDR_W-1:0] stk_peek,
  input  logic              stk_full,
  input  logic              stk_not_empty,
  output logic              halted,
  output logic              fault,
  output logic [1:0]        fault_code
);

  localparam logic [2:0] OP_NEXT = 3'd0;
  localparam logic [2:0] OP_JMP  = 3'd1;
  localparam logic [2:0] OP_BRZ  = 3'd2;
  localparam logic [2:0] OP_CALL = 3'd3;
  localparam logic [2:0] OP_RET  = 3'd4;
  localparam logic [2:0] OP_HALT = 3'd5;

  localparam logic [1:0] CODE_NONE  = 2'd0;
  localparam logic [1:0] CODE_OVER  = 2'd1;
  localparam logic [1:0] CODE_UNDER = 2'd2;

  typedef enum logic [1:0] {RUN, SETTLE, HALT, FAULT} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc_nxt;
  logic [ADDR_W-1:0] pc_inc;
  logic [1:0]        code_nxt;
  logic              accept;

  assign pc_inc = pc + ADDR_W'(1);
  assign accept = instr_valid && (state == RUN);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state      <= RUN;
      pc         <= RESET_VEC;
      fault_code <= CODE_NONE;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      fault_code <= code_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    code_nxt  = fault_code;
    case (state)
      SETTLE: state_nxt = RUN;
      RUN: begin
        if (accept) begin
          case (op)
            OP_JMP: pc_nxt = target;
            OP_BRZ: pc_nxt = zero ? target : pc_inc;
            OP_CALL: begin
              if (stk_full) begin
                state_nxt = FAULT;
                code_nxt  = CODE_OVER;
              end else begin
                state_nxt = SETTLE;
                pc_nxt    = target;
              end
            end
            OP_RET: begin
              if (!stk_not_empty) begin
                state_nxt = FAULT;
                code_nxt  = CODE_UNDER;
              end else begin
                state_nxt = SETTLE;
                pc_nxt    = stk_peek;
              end
            end
            OP_HALT: state_nxt = HALT;
            default: pc_nxt = pc_inc;
          endcase
        end
      end
      default: ;
    endcase
  end

  // Stack strobes are gated by the reset net so they collapse the moment clr falls.
  always_comb begin
    stk_en      = 1'b0;
    stk_c       = 1'b0;
    stk_push    = pc_inc;
    instr_ready = (state == RUN);
    halted      = (state == HALT);
    fault       = (state == FAULT);
    if (accept && clr) begin
      if (op == OP_CALL && !stk_full) begin
        stk_en = 1'b1;
        stk_c  = 1'b1;
      end else if (op == OP_RET && stk_not_empty) begin
        stk_en = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus random op streams, checked against
// an op-level reference model that also plays the role of the return-address stack.
module tb_pc_sequencer;

  localparam int DEPTH = 4;
  localparam logic [2:0] NEXT = 3'd0, JMP = 3'd1, BRZ = 3'd2, CALL = 3'd3,
                         RET = 3'd4, HLT = 3'd5, NOP = 3'd6;
  localparam int M_RUN = 0, M_SETTLE = 1, M_HALT = 2, M_FAULT = 3;

  logic       clk = 1'b0;
  logic       clr;
  logic       instr_valid;
  logic       instr_ready;
  logic [2:0] op;
  logic [7:0] target;
  logic       zero;
  logic [7:0] pc;
  logic [7:0] stk_push;
  logic       stk_c;
  logic       stk_en;
  logic [7:0] stk_peek;
  logic       stk_full;
  logic       stk_not_empty;
  logic       halted;
  logic       fault;
  logic [1:0] fault_code;

  int checks = 0;
  int errors = 0;

  // reference model: mode, pc, fault code and the stack contents
  int         m_mode;
  logic [7:0] m_pc;
  logic [1:0] m_code;
  logic [7:0] q[$];

  pc_sequencer #(.ADDR_W(8), .RESET_VEC(8'h00)) dut (
    .clk(clk), .clr(clr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .op(op), .target(target), .zero(zero), .pc(pc), .stk_push(stk_push),
    .stk_c(stk_c), .stk_en(stk_en), .stk_peek(stk_peek), .stk_full(stk_full),
    .stk_not_empty(stk_not_empty), .halted(halted), .fault(fault),
    .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_stack();
    stk_peek      = (q.size() != 0) ? q[$] : 8'h00;
    stk_full      = (q.size() == DEPTH);
    stk_not_empty = (q.size() != 0);
  endtask

  task automatic model_reset();
    m_mode = M_RUN;
    m_pc   = 8'h00;
    m_code = 2'd0;
    q.delete();
  endtask

  task automatic check_regs(input string tag);
    chk({tag, ".pc"}, 32'(pc), 32'(m_pc));
    chk({tag, ".halted"}, 32'(halted), 32'(m_mode == M_HALT));
    chk({tag, ".fault"}, 32'(fault), 32'(m_mode == M_FAULT));
    chk({tag, ".code"}, 32'(fault_code), 32'(m_code));
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr = 1'b0;
    instr_valid = 1'b0;
    model_reset();
    drive_stack();
    #1;
    chk("rst.en", 32'(stk_en), 32'd0);
    check_regs("rst");
    @(negedge clk);
    clr = 1'b1;
  endtask

  // One clock: offer an op, check the strobes before the edge and state after it.
  task automatic cycle(input logic v, input logic [2:0] o, input logic [7:0] t, input logic z);
    logic [7:0] inc, n_pc;
    logic [1:0] n_code;
    logic       acc, e_en, e_c, do_push, do_pop;
    int         n_mode;
    @(negedge clk);
    instr_valid = v; op = o; target = t; zero = z;
    drive_stack();
    #1;
    inc = m_pc + 8'd1;
    acc = v && (m_mode == M_RUN);
    e_en = 1'b0; e_c = 1'b0; do_push = 1'b0; do_pop = 1'b0;
    n_pc = m_pc; n_code = m_code;
    n_mode = (m_mode == M_SETTLE) ? M_RUN : m_mode;
    if (acc) begin
      case (o)
        JMP: n_pc = t;
        BRZ: n_pc = z ? t : inc;
        CALL: begin
          if (q.size() == DEPTH) begin n_mode = M_FAULT; n_code = 2'd1; end
          else begin e_en = 1'b1; e_c = 1'b1; do_push = 1'b1; n_pc = t; n_mode = M_SETTLE; end
        end
        RET: begin
          if (q.size() == 0) begin n_mode = M_FAULT; n_code = 2'd2; end
          else begin e_en = 1'b1; do_pop = 1'b1; n_pc = q[$]; n_mode = M_SETTLE; end
        end
        HLT: n_mode = M_HALT;
        default: n_pc = inc;
      endcase
    end
    chk("ready", 32'(instr_ready), 32'(m_mode == M_RUN));
    chk("stk_en", 32'(stk_en), 32'(e_en));
    chk("stk_c", 32'(stk_c), 32'(e_c));
    chk("stk_push", 32'(stk_push), 32'(inc));
    @(posedge clk);
    #1;
    if (do_push) q.push_back(inc);
    if (do_pop) void'(q.pop_back());
    m_pc = n_pc; m_mode = n_mode; m_code = n_code;
    check_regs("step");
  endtask

  initial begin
    clr = 1'b1; instr_valid = 1'b0; op = NEXT; target = 8'h00; zero = 1'b0;
    model_reset();
    drive_stack();

    // NEXT x3 from reset
    do_reset();
    cycle(1, NEXT, 8'h00, 0); chk("next1", 32'(pc), 32'h01);
    cycle(1, NOP, 8'h00, 0);  chk("next2", 32'(pc), 32'h02);
    cycle(1, NEXT, 8'h00, 0); chk("next3", 32'(pc), 32'h03);

    // CALL/RET round trip with a settle cycle each
    cycle(1, JMP, 8'h10, 0);
    cycle(1, CALL, 8'h40, 0);
    chk("call.pc", 32'(pc), 32'h40);
    chk("call.settle_ready", 32'(instr_ready), 32'd0);
    cycle(1, RET, 8'h00, 0);
    chk("settle.hold", 32'(pc), 32'h40);
    cycle(1, RET, 8'h00, 0);
    chk("ret.pc", 32'(pc), 32'h11);
    cycle(0, NEXT, 8'h00, 0);

    // Fill the stack, then overflow
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1, CALL, 8'(8'h20 + i * 8'h10), 0);
      cycle(0, NEXT, 8'h00, 0);
    end
    cycle(1, CALL, 8'h99, 0);
    chk("ovf.code", 32'(fault_code), 32'd1);
    cycle(1, NEXT, 8'h00, 0);
    cycle(1, JMP, 8'h77, 0);
    chk("ovf.frozen", 32'(pc), 32'h50);

    // Underflow straight after reset
    do_reset();
    cycle(1, RET, 8'h00, 0);
    chk("unf.code", 32'(fault_code), 32'd2);
    cycle(1, NEXT, 8'h00, 0);

    // Branches and wrap-around
    do_reset();
    cycle(1, JMP, 8'h05, 0); cycle(1, BRZ, 8'h20, 1); chk("brz.taken", 32'(pc), 32'h20);
    cycle(1, JMP, 8'h05, 0); cycle(1, BRZ, 8'h20, 0); chk("brz.fall", 32'(pc), 32'h06);
    cycle(1, JMP, 8'hFF, 0); cycle(1, NEXT, 8'h00, 0); chk("wrap", 32'(pc), 32'h00);
    cycle(1, JMP, 8'hFF, 0); cycle(1, CALL, 8'h33, 0); cycle(0, NEXT, 8'h00, 0);
    cycle(1, RET, 8'h00, 0); chk("wrap.ret", 32'(pc), 32'h00);
    cycle(0, NEXT, 8'h00, 0);

    // HALT, then ignored ops
    cycle(1, HLT, 8'h00, 0);
    chk("halt", 32'(halted), 32'd1);
    cycle(1, JMP, 8'h55, 0);
    cycle(1, CALL, 8'h66, 0);

    // Asynchronous reset in the middle of a CALL strobe
    do_reset();
    cycle(1, JMP, 8'h30, 0);
    @(negedge clk);
    instr_valid = 1'b1; op = CALL; target = 8'h44;
    drive_stack();
    #1;
    chk("async.en_before", 32'(stk_en), 32'd1);
    #2;
    clr = 1'b0;
    #1;
    model_reset();
    chk("async.en_after", 32'(stk_en), 32'd0);
    check_regs("async");
    @(negedge clk);
    instr_valid = 1'b0;
    clr = 1'b1;
    cycle(1, NEXT, 8'h00, 0);

    // Random op streams against the model
    for (int r = 0; r < 15; r++) begin
      do_reset();
      for (int k = 0; k < 40; k++) begin
        logic [2:0] ro;
        ro = 3'($urandom_range(0, 7));
        if (ro == HLT && $urandom_range(0, 3) != 0) ro = CALL;
        cycle(1'($urandom_range(0, 3) != 0), ro, 8'($urandom), 1'($urandom));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Program-counter sequencer that sits directly upstream of the return-address stack. It decodes control-flow ops (next, jump, branch-on-zero, call, return, halt) and owns the PC. It drives the stack's push/control/enable lines and consumes its peek/full/not_empty outputs. After every stack operation it inserts one settle cycle so that the stack's registered peek is refreshed before the next return.

Parameters:
ADDR_W, 8, PC width; equals the stack data width.
RESET_VEC, 0, PC value loaded on reset.

Ports:
clk  input  1  system clock, rising edge
clr  input  1  asynchronous, active-low reset (clr=0 resets)
instr_valid  input  1  op/target/zero are valid this cycle
instr_ready  output  1  sequencer accepts an op this cycle
op  input  3  0=NEXT, 1=JMP, 2=BRZ, 3=CALL, 4=RET, 5=HALT, 6-7=NOP (treated as NEXT)
target  input  ADDR_W  jump/branch/call destination
zero  input  1  ALU zero flag, sampled for BRZ
pc  output  ADDR_W  current program counter (registered)
stk_push  output  ADDR_W  value to push (return address)
stk_c  output  1  stack control: 1=push, 0=pop
stk_en  output  1  stack enable
stk_peek  input  ADDR_W  stack top-of-stack value
stk_full  input  1  stack full
stk_not_empty  input  1  stack holds at least one entry
halted  output  1  sequencer is in HALT
fault  output  1  sticky stack-fault flag
fault_code  output  2  0=none, 1=overflow (CALL when full), 2=underflow (RET when empty)

Behaviour:
- Reset (clr=0, async): pc=RESET_VEC, state=RUN, halted=0, fault=0, fault_code=0. stk_en=0 while in reset. The stack's own clear is driven from the same reset net.
- States: RUN, SETTLE, HALT, FAULT.
- instr_ready=1 only in RUN. An op is accepted when instr_valid&&instr_ready. No op is accepted in the other states.
- stk_en, stk_c and stk_push are combinational from state and accepted op. Defaults: stk_en=0, stk_c=0, stk_push=pc+1.
- RUN, no accepted op: hold pc; stk_en=0.
- RUN, NEXT/NOP: pc<=pc+1; stay in RUN.
- RUN, JMP: pc<=target; stay in RUN.
- RUN, BRZ: pc<=target if zero=1, else pc<=pc+1; stay in RUN.
- RUN, CALL with stk_full=0: stk_en=1, stk_c=1, stk_push=pc+1, pc<=target; go to SETTLE.
- RUN, CALL with stk_full=1: no stack strobe, pc held, fault<=1, fault_code<=1; go to FAULT.
- RUN, RET with stk_not_empty=1: pc<=stk_peek, sampled in the accepting cycle. Also stk_en=1, stk_c=0 (pop); go to SETTLE.
- RUN, RET with stk_not_empty=0: no strobe, pc held, fault<=1, fault_code<=2; go to FAULT.
- RUN, HALT: pc held, halted<=1; go to HALT.
- SETTLE: exactly 1 cycle, stk_en=0 (lets the stack reload peek), pc held; then return to RUN.
- HALT and FAULT are terminal until reset. Outputs are held and stk_en=0. In FAULT, halted stays 0.
- Arithmetic: pc+1 wraps modulo 2^ADDR_W (all-ones+1 = 0). A CALL at pc=all-ones pushes 0.
- Latency: every op updates pc on the clock edge after acceptance. CALL/RET cost 2 cycles (accept + SETTLE).
- Flag values are sampled in the accept cycle; later changes have no effect.
- Reset asserted mid-SETTLE or mid-strobe: returns to RUN/RESET_VEC immediately, and stk_en drops asynchronously.

Test Plan:
- Reset then NEXT x3 with RESET_VEC=0 -> pc 0,1,2,3; instr_ready=1 throughout; stk_en never asserted.
- pc=0x10, CALL target=0x40 -> that cycle stk_en=1,c=1,push=0x11; next pc=0x40 with instr_ready=0 for one cycle. A following RET (peek=0x11) -> pc=0x11, pop strobe, one SETTLE cycle.
- Nested CALLs until stk_full=1, then one more CALL -> no strobe, fault=1, fault_code=1, pc frozen, instr_ready=0 until reset.
- RET after reset (stk_not_empty=0) -> fault=1, fault_code=2, stk_en stays 0.
- BRZ target=0x20 from pc=0x05: zero=1 -> pc=0x20; zero=0 -> pc=0x06. At pc=0xFF, NEXT -> pc=0x00; CALL at 0xFF pushes 0x00.
- Assert clr=0 asynchronously during a CALL cycle -> stk_en drops before the next edge, pc=RESET_VEC, fault=0, halted=0. HALT op -> halted=1, later instr_valid ignored.
